ifetch16: RTL and testbench

Instruction fetch stage sitting directly upstream of `core8`: it owns the program counter, requests 16-bit instruction words from instruction memory over a req/ack handshake, and prefetches them into a small FIFO. The FIFO head drives `core8.inst`. The core's fetch strobe (IR input enable) pops the head. A redirect input flushes the prefetch state and restarts fetching at a new address.

---
 rtl/ifetch16.sv | 180 ++++++++++++++++++
 tb/tb_ifetch16.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch16.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch16
//  Purpose  : Instruction fetch stage. Owns the program counter, fetches
//             16-bit words from instruction memory over a single-outstanding
//             req/ack handshake and prefetches them into a small FIFO whose
//             head feeds the core. A redirect flushes the prefetch state and
//             restarts fetching at a new address.
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch16 #(
  parameter int AW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  // instruction memory side
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  // core side
  input  logic          take,
  output logic [15:0]   inst,
  output logic          inst_valid,
  output logic [AW-1:0] inst_pc,
  // redirect
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr
);

  // FIFO pointer and occupancy widths; DEPTH is a power of two so pointers
  // wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // IDLE : no request on the bus
  // REQ  : request on the bus whose data will be kept
  // DROP : request on the bus whose data is stale (redirect arrived mid-wait)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]   count_if_push;
  logic [AW-1:0]   pc_inc;
  logic            push;
  logic            pop;
  logic            not_empty;

  // FIFO payload storage; contents are only observed through the valid gate,
  // so the arrays need no reset.
  logic [15:0]     inst_mem [DEPTH];
  logic [AW-1:0]   pc_mem   [DEPTH];

  assign not_empty = (count != '0);

  // A redirect takes priority over a pop; popping an empty FIFO is a no-op.
  assign pop = take && not_empty && !jmp;

  // Occupancy after a push this cycle, accounting for a same-cycle pop.
  assign count_if_push = pop ? count : (count + CW'(1));

  assign pc_inc = pc + AW'(1);

  // Next-state, PC, request address and push decision.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_q;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (jmp) begin
          // Stay idle one cycle; the request to jmp_addr issues next edge.
          pc_nxt = jmp_addr;
        end else if (count < FULL) begin
          addr_nxt  = pc;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (jmp) begin
          pc_nxt = jmp_addr;
          // An acked word is simply discarded; an unacked request must be
          // allowed to complete on the bus, so its data is dropped later.
          state_nxt = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push   = 1'b1;
          pc_nxt = pc_inc;
          if (count_if_push < FULL) begin
            addr_nxt  = pc_inc;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (jmp) begin
          pc_nxt = jmp_addr;
        end
        if (imem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FIFO occupancy and pointer updates; a redirect flushes everything.
  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (jmp) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count_nxt = count + CW'(1);
      end else if (pop && !push) begin
        count_nxt = count - CW'(1);
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      addr_q <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      addr_q <= addr_nxt;
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  // Capture the returned word together with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= addr_q;
    end
  end

  // Request is decoded from the state register so reset drops it at once.
  assign imem_req   = (state == REQ) || (state == DROP);
  assign imem_addr  = addr_q;
  assign inst_valid = not_empty;
  assign inst       = not_empty ? inst_mem[rd_ptr] : 16'h0000;
  assign inst_pc    = not_empty ? pc_mem[rd_ptr]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch16
//  Purpose  : Self-checking bench for ifetch16: directed vector table,
//             hand-written redirect / wait-state sequences and a randomized
//             run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch16;

  localparam int AW    = 8;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_data;
  logic          take;
  logic [15:0]   inst;
  logic          inst_valid;
  logic [AW-1:0] inst_pc;
  logic          jmp;
  logic [AW-1:0] jmp_addr;

  ifetch16 #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .take       (take),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the prefetch buffer as a queue of fetched words, the
  // next address the stage should fetch, and whether the word on the bus is
  // stale because of a redirect.
  typedef struct {
    logic [15:0]   ins;
    logic [AW-1:0] pc;
  } ent_t;
  ent_t          mq[$];
  logic [AW-1:0] mpc;
  bit            mdrop;
  int            gap;

  // Memory model state.
  int wcnt;
  int cur_lat;
  int mem_lat;
  bit rand_lat;

  function automatic logic [15:0] word_at(input logic [AW-1:0] a);
    return 16'hE000 + {8'h00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = '0;
    mdrop = 1'b0;
    gap   = 0;
  endtask

  // Advance the model by one clock edge given what was on the pins before it.
  task automatic model_edge(input logic s_req, input logic s_ack, input logic [AW-1:0] s_addr,
                            input logic s_take, input logic s_jmp, input logic [AW-1:0] s_jaddr);
    ent_t e;
    if (s_jmp) begin
      mq.delete();
      if (s_req && s_ack) mdrop = 1'b0;
      else if (s_req)     mdrop = 1'b1;
      mpc = s_jaddr;
    end else begin
      if (s_take && mq.size() > 0) void'(mq.pop_front());
      if (s_req && s_ack) begin
        if (mdrop) begin
          mdrop = 1'b0;
        end else begin
          chk("fetch_addr", s_addr, mpc);
          e.ins = word_at(mpc);
          e.pc  = mpc;
          mq.push_back(e);
          chk("fifo_bound", (mq.size() <= DEPTH), 1);
          mpc = mpc + 8'd1;
        end
      end
    end
  endtask

  // Memory: acks cur_lat cycles after a request appears, one word per ack.
  task automatic mem_respond(input logic s_req, input logic s_ackd, input logic [AW-1:0] s_addr);
    if (s_req && !s_ackd) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, s_addr);
    end
    if (!imem_req) begin
      imem_ack  = 1'b0;
      imem_data = 16'hDEAD;
      wcnt      = 0;
    end else begin
      if (!s_req || s_ackd) begin
        wcnt    = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (wcnt >= cur_lat) begin
        imem_ack  = 1'b1;
        imem_data = word_at(imem_addr);
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        wcnt++;
      end
    end
  endtask

  task automatic model_check(input logic s_jmp);
    logic [15:0]   eins;
    logic [AW-1:0] epc;
    eins = (mq.size() > 0) ? mq[0].ins : 16'h0000;
    epc  = (mq.size() > 0) ? mq[0].pc  : '0;
    chk("m_valid", inst_valid, (mq.size() > 0));
    chk("m_inst", inst, eins);
    chk("m_pc", inst_pc, epc);
    // A free slot must not leave the bus idle for more than one cycle.
    if (s_jmp) gap = 0;
    else if (!imem_req && mq.size() < DEPTH) gap++;
    else gap = 0;
    chk("m_stall", (gap <= 1), 1);
  endtask

  // One clock: snapshot pins, advance model, clock, respond, check.
  task automatic step();
    logic s_req, s_ack, s_take, s_jmp;
    logic [AW-1:0] s_addr, s_jaddr;
    s_req = imem_req; s_ack = imem_ack; s_addr = imem_addr;
    s_take = take; s_jmp = jmp; s_jaddr = jmp_addr;
    model_edge(s_req, s_ack, s_addr, s_take, s_jmp, s_jaddr);
    @(posedge clk);
    #1;
    mem_respond(s_req, s_req && s_ack, s_addr);
    model_check(s_jmp);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_inst", inst, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", inst_pc, 0);
    model_reset();
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    wcnt      = 0;
    take      = 1'b0;
    jmp       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input logic [AW-1:0] exp_addr);
    int i;
    i = 0;
    while (!imem_ack && i < 8) begin
      step();
      chk("wait_addr", imem_addr, exp_addr);
      i++;
    end
    chk("ack_timeout", imem_ack, 1);
  endtask

  typedef struct {
    bit            take;
    bit            jmp;
    logic [AW-1:0] jaddr;
    bit            req;
    logic [AW-1:0] addr;
    bit            valid;
    logic [AW-1:0] pc;
  } vec_t;
  vec_t tbl[17];

  initial begin
    rst = 1'b0; take = 1'b0; jmp = 1'b0; jmp_addr = '0;
    imem_ack = 1'b0; imem_data = 16'h0000;
    mem_lat = 0; rand_lat = 1'b0; cur_lat = 0; wcnt = 0;
    model_reset();

    // Zero-wait memory: start-up, backpressure, throughput, redirect, wrap.
    //            take jmp jaddr  req addr   valid pc
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h03};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h04};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h05};
    tbl[12] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00};
    tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      take     = tbl[i].take;
      jmp      = tbl[i].jmp;
      jmp_addr = tbl[i].jaddr;
      step();
      chk($sformatf("t%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), inst_valid, tbl[i].valid);
      chk($sformatf("t%0d_pc", i), inst_pc, tbl[i].pc);
      chk($sformatf("t%0d_inst", i), inst, tbl[i].valid ? word_at(tbl[i].pc) : 16'h0000);
    end
    take = 1'b0; jmp = 1'b0;

    // Redirect while a 2-wait request to address 5 is pending; reset lands
    // while a request is on the bus.
    mem_lat = 2;
    do_reset();
    jmp = 1'b1; jmp_addr = 8'h05;
    step();
    chk("b_idle", imem_req, 0);
    jmp = 1'b0;
    step();
    chk("b_req5", imem_req, 1);
    chk("b_addr5", imem_addr, 8'h05);
    jmp = 1'b1; jmp_addr = 8'h40;
    step();
    jmp = 1'b0;
    chk("b_drop_req", imem_req, 1);
    chk("b_drop_addr", imem_addr, 8'h05);
    wait_ack(8'h05);
    step();
    chk("b_after_drop_valid", inst_valid, 0);
    chk("b_after_drop_req", imem_req, 0);
    step();
    chk("b_req40", imem_req, 1);
    chk("b_addr40", imem_addr, 8'h40);
    begin
      int k;
      k = 0;
      while (!inst_valid && k < 10) begin
        step();
        k++;
      end
    end
    chk("b_first_valid", inst_valid, 1);
    chk("b_first_pc", inst_pc, 8'h40);
    chk("b_first_inst", inst, 16'hE040);

    // Three wait states; push and pop collide at count 1.
    mem_lat = 3;
    do_reset();
    jmp = 1'b1; jmp_addr = 8'h10;
    step();
    jmp = 1'b0;
    step();
    chk("c_addr10", imem_addr, 8'h10);
    wait_ack(8'h10);
    step();
    chk("c_valid1", inst_valid, 1);
    chk("c_pc10", inst_pc, 8'h10);
    chk("c_addr11", imem_addr, 8'h11);
    wait_ack(8'h11);
    take = 1'b1;
    step();
    take = 1'b0;
    chk("c_pushpop_valid", inst_valid, 1);
    chk("c_pushpop_pc", inst_pc, 8'h11);
    chk("c_pushpop_inst", inst, 16'hE011);
    chk("c_next_addr", imem_addr, 8'h12);

    // Randomized traffic against the model.
    rand_lat = 1'b1;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      take = ($urandom_range(0, 99) < 55);
      jmp  = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 2))
        0:       jmp_addr = 8'hFE;
        1:       jmp_addr = 8'hFF;
        default: jmp_addr = 8'($urandom);
      endcase
      step();
    end
    take = 1'b0; jmp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
